// File: rtl/ctrl_encode_def.sv
// Shared control encodings: ALU opcodes, multiply/divide opcodes and the
// multiply/divide sequencer state encoding.
package ctrl_encode_def;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  // Codes 6 and 7 are left unassigned and act as NOPs in the mul/div unit.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate; carry_in lets two instances chain
// into a double-width negate (low half feeds the high half's increment).
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + {{(WIDTH-1){1'b0}}, carry_in}) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Signed operations run on magnitudes; the FIX state restores the signs.
module muldiv_unit
  import ctrl_encode_def::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;    // product upper half / partial remainder
  logic [WIDTH-1:0] mq;     // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] opnd;   // multiplicand / divisor magnitude
  logic             neg_lo;
  logic             neg_hi;
  logic             is_div;
  logic             div_zero;

  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] fix_hi;
  logic             hi_carry;

  logic             as_sub;
  logic [WIDTH:0]   as_x;
  logic [WIDTH:0]   as_y;
  logic [WIDTH:0]   as_sum;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  // A product negates as one 2*WIDTH value; quotient and remainder separately.
  assign hi_carry  = is_div | (mq == '0);

  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (
    .value(a), .negate(a_neg), .carry_in(1'b1), .result(abs_a)
  );
  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (
    .value(b), .negate(b_neg), .carry_in(1'b1), .result(abs_b)
  );
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_lo (
    .value(mq), .negate(neg_lo), .carry_in(1'b1), .result(fix_lo)
  );
  muldiv_signfix #(.WIDTH(WIDTH)) u_fix_hi (
    .value(acc), .negate(neg_hi), .carry_in(hi_carry), .result(fix_hi)
  );

  // Single WIDTH+1 bit adder/subtractor shared by shift-add and restoring divide.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    as_sub = 1'b0;
    as_x   = {1'b0, acc};
    as_y   = {1'b0, opnd};
    if (state == S_DIV) begin
      as_sub = 1'b1;
      as_x   = {acc, mq[WIDTH-1]};
    end else if (!mq[0]) begin
      as_y   = '0;
    end
    as_sum = as_x + (as_y ^ {(WIDTH+1){as_sub}}) + {{WIDTH{1'b0}}, as_sub};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      opnd     <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              case (md_op_e'(op))
                OP_MULT, OP_MULTU: begin
                  state    <= S_MUL;
                  busy     <= 1'b1;
                  acc      <= '0;
                  mq       <= abs_a;
                  opnd     <= abs_b;
                  neg_lo   <= a_neg ^ b_neg;
                  neg_hi   <= a_neg ^ b_neg;
                  is_div   <= 1'b0;
                  div_zero <= 1'b0;
                end
                OP_DIV, OP_DIVU: begin
                  state    <= S_DIV;
                  busy     <= 1'b1;
                  acc      <= '0;
                  mq       <= abs_a;
                  opnd     <= abs_b;
                  neg_lo   <= a_neg ^ b_neg;
                  neg_hi   <= a_neg;
                  is_div   <= 1'b1;
                  div_zero <= (b == '0);
                end
                OP_MTHI: hi <= a;
                OP_MTLO: lo <= a;
                default: ;
              endcase
            end
          end
          S_MUL, S_DIV: begin
            if (state == S_MUL) begin
              acc <= as_sum[WIDTH:1];
              mq  <= {as_sum[0], mq[WIDTH-1:1]};
            end else if (!as_sum[WIDTH]) begin
              acc <= as_sum[WIDTH-1:0];
              mq  <= {mq[WIDTH-2:0], 1'b1};
            end else begin
              acc <= {acc[WIDTH-2:0], mq[WIDTH-1]};
              mq  <= {mq[WIDTH-2:0], 1'b0};
            end
            if (cnt == CNT_W'(WIDTH - 1)) begin
              cnt   <= '0;
              state <= S_FIX;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_FIX: begin
            hi    <= fix_hi;
            lo    <= div_zero ? '1 : fix_lo;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width (even, >= 4).
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width (2**CNT_W > WIDTH).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; accepted only when busy=0.
REQ-006 op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO; other codes are NOP.
REQ-007 a  input  WIDTH  operand A (multiplicand / dividend / MTHI-MTLO data).
REQ-008 b  input  WIDTH  operand B (multiplier / divisor).
REQ-009 flush  input  1  abort in-flight operation.
REQ-010 busy  output  1  iterative operation in progress.
REQ-011 done  output  1  one-cycle pulse on HI/LO update by MULT/MULTU/DIV/DIVU.
REQ-012 hi  output  WIDTH  HI register (product upper half / remainder).
REQ-013 lo  output  WIDTH  LO register (product lower half / quotient).

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV, FIX; reset state IDLE.
REQ-015 IDLE + start + MULT/MULTU -> MUL; + DIV/DIVU -> DIV; operands latched, signed ops latch magnitudes plus result-sign flags.
REQ-016 MUL, DIV SHALL run exactly WIDTH radix-2 iterations (shift-add / restoring), then -> FIX.
REQ-017 FIX SHALL apply sign correction, write hi/lo, pulse done, -> IDLE.
REQ-018 Latency: start accepted at edge N; hi/lo valid and done=1 after edge N+WIDTH+1; busy=1 from edge N to edge N+WIDTH+1.
REQ-019 Back-to-back: start in the cycle done=1 SHALL be accepted (busy=0 that cycle).
REQ-020 start while busy=1 SHALL be ignored; hi/lo unchanged until FIX.
REQ-021 MTHI/MTLO in IDLE SHALL write a to hi/lo at the accepting edge, no busy, no done.
REQ-022 NOP op with start SHALL change nothing.
REQ-023 MULT: signed 2*WIDTH product; MULTU: unsigned; hi=upper WIDTH bits, lo=lower.
REQ-024 DIV: quotient truncates toward zero, remainder takes dividend sign; DIVU unsigned.
REQ-025 Divide by zero (b=0): lo = all ones, hi = a, normal latency, done pulses.
REQ-026 Signed overflow (a = most-negative, b = -1): lo = a, hi = 0.
REQ-027 Most-negative operands SHALL be handled via WIDTH+1-bit magnitude, no overflow in MULT.
REQ-028 flush SHALL force IDLE next edge, busy=0, no done, hi/lo keep prior values; flush overrides start.

Reset
REQ-029 rstn=0 SHALL asynchronously set state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, including mid-operation.
REQ-030 First start SHALL be accepted on the first edge with rstn=1.

Structure
REQ-031 op encodings, state encoding SHALL live in the shared ctrl_encode_def package alongside ALU opcodes.
REQ-032 One sub-module muldiv_signfix (combinational abs/negate, width WIDTH) SHALL be used for operand magnitude and FIX correction.
REQ-033 No multiplier/divider primitives; datapath SHALL be one adder/subtractor of WIDTH+1 bits.

Verification (WIDTH=32)
REQ-034 MULT a=0xFFFFFFFD(-3), b=7 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, done one cycle.
REQ-035 MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234; DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-037 MULT started, second start (DIVU) at cycle 5 -> ignored, MULT result only; start at done cycle -> accepted.
REQ-038 rstn low at cycle 10 of DIV -> busy=0, hi=lo=0 immediately, no done; flush at cycle 10 -> no done, hi/lo retain MTHI/MTLO values.
